csr_unit: RTL and testbench
===========================

# csr_unit

Machine-mode CSR and interrupt controller in the EXE stage. Executes CSRRW/CSRRS/CSRRC, MRET and WFI for the instruction held in the ID/EXE register. Takes external and timer interrupts, and keeps 64-bit cycle and instret counters. Drives the CSR stall, pipeline flush and PC redirect signals into the IF/ID, ID/EXE and EXE/MEM registers and the PC mux.

## Interface
- RESET_VEC, 32'h0: reset value of mtvec.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- exe_valid  in  1  EXE holds a real instruction, not a bubble.
- exe_pc  in  32  PC of the EXE instruction.
- csr_sel  in  1  EXE instruction is a CSR-class instruction.
- csr_type  in  2  operation code:
  - 00: system (MRET/WFI, chosen by csr_addr).
  - 01: RW.
  - 10: RS.
  - 11: RC.
- csr_addr  in  12  CSR address. For type 00: 12'h302 = MRET, 12'h105 = WFI.
- csr_wdata  in  32  source operand; rs1 or zero-extended uimm, already muxed.
- im_stall, dm_stall  in  1 each  memory stalls.
- instr_retire  in  1  one instruction retired in WB this cycle.
- ext_irq, timer_irq  in  1 each  level-sensitive interrupt requests.
- csr_rdata  out  32  old CSR value, written back to rd.
- csr_stall  out  1  freeze the pipeline (WFI).
- csr_flush  out  1  flush IF/ID, ID/EXE and the EXE/MEM write enables.
- csr_pc_sel  out  1  select csr_target as the next PC.
- csr_target  out  32  redirect PC.

## Operation
**CSRs implemented**
- mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] hardwired 2'b11, all other bits read 0.
- mie 0x304: MEIE[11], MTIE[7].
- mip 0x344: read-only. MEIP[11] = ext_irq, MTIP[7] = timer_irq.
- mtvec 0x305: direct mode only; bits [1:0] forced 0.
- mepc 0x341: bits [1:0] forced 0.
- mcause 0x342.
- Counters, read-only: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82.
- Unknown address: reads 0; writes are ignored.

**CSR access**
- csr_rdata is combinational and always returns the pre-write value.
- Write value per op: RW = wdata; RS = old | wdata; RC = old & ~wdata.
- RS/RC with wdata = 0 leave the register unchanged.
- Writes to read-only CSRs are dropped.

**Terms used below**
- commit = exe_valid & ~im_stall & ~dm_stall.
- pend = (mip & mie) != 0.
- take = mstatus.MIE & pend.

**State machine: RUN, WFI_WAIT**
- RUN, take & commit (interrupt entry):
  - Assert csr_flush, csr_pc_sel; csr_target = mtvec.
  - mepc <= exe_pc.
  - mcause <= 32'h8000000B for external, else 32'h80000007. External has priority over timer.
  - MPIE <= MIE, MIE <= 0.
  - The EXE instruction is squashed; its CSR op, MRET or WFI has no effect.
- RUN, commit MRET:
  - Assert csr_flush, csr_pc_sel; csr_target = mepc.
  - MIE <= MPIE, MPIE <= 1.
- RUN, commit WFI:
  - If pend: behaves as a NOP.
  - Otherwise: csr_stall = 1 this cycle, latch wfi_pc = exe_pc + 4, go to WFI_WAIT.
- WFI_WAIT:
  - csr_stall = 1 while ~pend.
  - On pend with take: interrupt entry as above, but mepc <= wfi_pc. Return to RUN.
  - On pend without take: drop csr_stall, return to RUN, execution resumes after the WFI.
- Reset mid-WFI returns the block to RUN with csr_stall = 0.

**Counters**
- cycle increments every clock after reset release.
- instret increments on instr_retire.
- Both are 64-bit and wrap to 0 past 2^64 − 1.
- cycleh/instreth return bits [63:32] of the live counter value.

## Timing
- Reset values:
  - mstatus = 32'h1800, mie = 0, mtvec = RESET_VEC, mepc = 0, mcause = 0.
  - cycle = 0, instret = 0, state RUN.
  - csr_stall = csr_flush = csr_pc_sel = 0.
- csr_flush, csr_pc_sel and csr_target are combinational and valid in the same cycle as commit.
- CSR state updates on the following rising edge.
- While im_stall or dm_stall is high:
  - csr_flush and csr_pc_sel are forced 0.
  - No CSR, mepc or mstatus update; counters still run.
  - The held EXE instruction is re-evaluated after release.
- A CSR write to mie/mstatus is visible to take in the next cycle, not the current one.
- Simultaneous interrupt and MRET/CSR op: the interrupt wins.
- Simultaneous instr_retire and a write attempt to instret: the increment happens and the write is dropped.

## Structure
- Package csr_pkg holds:
  - CSR address localparams.
  - csr_op_e enum (SYS/RW/RS/RC).
  - csr_state_e enum (RUN/WFI_WAIT).
  - mcause code constants.
  - MRET/WFI selector constants.
- Sub-module csr_counter64 (clk, reset, inc, value[63:0]) is instantiated for cycle and for instret.

## Test plan
- Reset, then idle 5 cycles: read 0xC00 → 5; read 0x300 → 32'h1800; all outputs 0 during reset.
- CSRRW 0x305 with wdata 32'h0000_1003 → rdata = RESET_VEC; a subsequent read → 32'h0000_1000.
- Set MIE and MEIE, then raise ext_irq with exe_pc = 0x40 → csr_flush = csr_pc_sel = 1, target = mtvec, mepc = 0x40, mcause = 32'h8000000B, MIE = 0, MPIE = 1.
- MRET after the previous scenario → target = 0x40, MIE = 1; with dm_stall high the MRET is held (flush 0) and fires the cycle after release.
- WFI at pc 0x80 with nothing pending → csr_stall held high. Raising timer_irq with MTIE = 1, MIE = 1 gives mepc = 0x84, mcause = 32'h80000007. Repeating with MIE = 0 just drops the stall.
- Drive instr_retire 3 times together with a CSRRW attempt on 0xC02 → instret = 3.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit:
// CSR addresses, operation and state encodings, trap cause codes.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    localparam logic [11:0] SYS_MRET = 12'h302;
    localparam logic [11:0] SYS_WFI  = 12'h105;

    localparam logic [31:0] MCAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_TIMER = 32'h8000_0007;

    typedef enum logic [1:0] {
        OP_SYS = 2'b00,
        OP_RW  = 2'b01,
        OP_RS  = 2'b10,
        OP_RC  = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_RUN,
        ST_WFI_WAIT
    } csr_state_e;

    function automatic logic [31:0] csr_apply(
        input csr_op_e     op,
        input logic [31:0] old,
        input logic [31:0] wd
    );
        logic [31:0] r;
        r = old;
        unique case (op)
            OP_RW:   r = wd;
            OP_RS:   r = old | wd;
            OP_RC:   r = old & ~wd;
            default: r = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running 64-bit event counter, wraps to zero.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [63:0] value
);

    logic [63:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// EXE-stage machine-mode CSR file, interrupt entry, MRET/WFI
// handling and the cycle/instret counters.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_valid,
    input  logic [31:0] exe_pc,
    input  logic        csr_sel,
    input  logic [1:0]  csr_type,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        im_stall,
    input  logic        dm_stall,
    input  logic        instr_retire,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        csr_stall,
    output logic        csr_flush,
    output logic        csr_pc_sel,
    output logic [31:0] csr_target
);

    csr_state_e  state_q, state_d;
    logic        mstie_q, mstie_d;
    logic        mpie_q, mpie_d;
    logic        meie_q, meie_d;
    logic        mtie_q, mtie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] wfi_pc_q, wfi_pc_d;

    logic [63:0] cycle_w, instret_w;
    logic [31:0] mstatus_v, mie_v, mip_v, wval, irq_pc;
    logic        mem_ok, commit, pend, take, ext_win;
    logic        is_sys, is_mret, is_wfi, wr_en, irq_entry;
    csr_op_e     op;

    csr_counter64 u_cycle (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .value (cycle_w)
    );

    csr_counter64 u_instret (
        .clk   (clk),
        .reset (reset),
        .inc   (instr_retire),
        .value (instret_w)
    );

    assign op        = csr_op_e'(csr_type);
    assign mstatus_v = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mstie_q, 3'b0};
    assign mie_v     = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
    assign mip_v     = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};

    assign mem_ok  = ~im_stall & ~dm_stall;
    assign commit  = exe_valid & mem_ok;
    assign pend    = |(mip_v & mie_v);
    assign take    = mstie_q & pend;
    assign ext_win = ext_irq & meie_q;

    assign is_sys  = csr_sel & (op == OP_SYS);
    assign is_mret = is_sys & (csr_addr == SYS_MRET);
    assign is_wfi  = is_sys & (csr_addr == SYS_WFI);
    // Set/clear with a zero operand is a pure read.
    assign wr_en   = csr_sel & (op != OP_SYS)
                   & ((op == OP_RW) | (csr_wdata != '0));
    assign wval    = csr_apply(op, csr_rdata, csr_wdata);

    always_comb begin
        csr_rdata = '0;
        unique case (csr_addr)
            CSR_MSTATUS:  csr_rdata = mstatus_v;
            CSR_MIE:      csr_rdata = mie_v;
            CSR_MIP:      csr_rdata = mip_v;
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_CYCLE:    csr_rdata = cycle_w[31:0];
            CSR_CYCLEH:   csr_rdata = cycle_w[63:32];
            CSR_INSTRET:  csr_rdata = instret_w[31:0];
            CSR_INSTRETH: csr_rdata = instret_w[63:32];
            default:      csr_rdata = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mstie_d    = mstie_q;
        mpie_d     = mpie_q;
        meie_d     = meie_q;
        mtie_d     = mtie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        wfi_pc_d   = wfi_pc_q;
        csr_stall  = 1'b0;
        csr_flush  = 1'b0;
        csr_pc_sel = 1'b0;
        csr_target = mtvec_q;
        irq_entry  = 1'b0;
        irq_pc     = exe_pc;

        unique case (state_q)
            ST_RUN: begin
                if (commit && take) begin
                    irq_entry = 1'b1;
                end else if (commit && is_mret) begin
                    csr_flush  = 1'b1;
                    csr_pc_sel = 1'b1;
                    csr_target = mepc_q;
                    mstie_d    = mpie_q;
                    mpie_d     = 1'b1;
                end else if (commit && is_wfi && !pend) begin
                    csr_stall = 1'b1;
                    wfi_pc_d  = exe_pc + 32'd4;
                    state_d   = ST_WFI_WAIT;
                end else if (commit && wr_en) begin
                    unique case (csr_addr)
                        CSR_MSTATUS: begin
                            mstie_d = wval[3];
                            mpie_d  = wval[7];
                        end
                        CSR_MIE: begin
                            meie_d = wval[11];
                            mtie_d = wval[7];
                        end
                        CSR_MTVEC:  mtvec_d  = wval & ~32'h3;
                        CSR_MEPC:   mepc_d   = wval & ~32'h3;
                        CSR_MCAUSE: mcause_d = wval;
                        default:    ;
                    endcase
                end
            end
            ST_WFI_WAIT: begin
                if (!pend) begin
                    csr_stall = 1'b1;
                end else if (take) begin
                    if (mem_ok) begin
                        irq_entry = 1'b1;
                        irq_pc    = wfi_pc_q;
                        state_d   = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (irq_entry) begin
            csr_flush  = 1'b1;
            csr_pc_sel = 1'b1;
            csr_target = mtvec_q;
            mepc_d     = irq_pc & ~32'h3;
            mcause_d   = ext_win ? MCAUSE_EXT : MCAUSE_TIMER;
            mpie_d     = mstie_q;
            mstie_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            mstie_q  <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            mtvec_q  <= RESET_VEC;
            mepc_q   <= '0;
            mcause_q <= '0;
            wfi_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            mstie_q  <= mstie_d;
            mpie_q   <= mpie_d;
            meie_q   <= meie_d;
            mtie_q   <= mtie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            wfi_pc_q <= wfi_pc_d;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit; expectations are queued by the
// stimulus and checked by a monitor on the falling edge.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exe_valid = 1'b0;
    logic [31:0] exe_pc = '0;
    logic        csr_sel = 1'b0;
    logic [1:0]  csr_type = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic        im_stall = 1'b0;
    logic        dm_stall = 1'b0;
    logic        instr_retire = 1'b0;
    logic        ext_irq = 1'b0;
    logic        timer_irq = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_stall;
    logic        csr_flush;
    logic        csr_pc_sel;
    logic [31:0] csr_target;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [31:0] rd;
        bit          crd;
        logic        st;
        logic        fl;
        logic        ps;
        logic [31:0] tg;
        bit          ctg;
    } exp_t;

    exp_t sb[$];

    csr_unit #(.RESET_VEC(32'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .exe_valid    (exe_valid),
        .exe_pc       (exe_pc),
        .csr_sel      (csr_sel),
        .csr_type     (csr_type),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .im_stall     (im_stall),
        .dm_stall     (dm_stall),
        .instr_retire (instr_retire),
        .ext_irq      (ext_irq),
        .timer_irq    (timer_irq),
        .csr_rdata    (csr_rdata),
        .csr_stall    (csr_stall),
        .csr_flush    (csr_flush),
        .csr_pc_sel   (csr_pc_sel),
        .csr_target   (csr_target)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, string f, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s got %h want %h", nm, f, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.crd) chk(e.nm, "rdata", csr_rdata, e.rd);
            chk(e.nm, "stall", {31'b0, csr_stall}, {31'b0, e.st});
            chk(e.nm, "flush", {31'b0, csr_flush}, {31'b0, e.fl});
            chk(e.nm, "pc_sel", {31'b0, csr_pc_sel}, {31'b0, e.ps});
            if (e.ctg) chk(e.nm, "target", csr_target, e.tg);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(logic v, logic [31:0] pc, logic sel, logic [1:0] ty,
                       logic [11:0] a, logic [31:0] wd);
        exe_valid = v;
        exe_pc    = pc;
        csr_sel   = sel;
        csr_type  = ty;
        csr_addr  = a;
        csr_wdata = wd;
    endtask

    task automatic expect_out(string nm, logic [31:0] rd, bit crd, logic st,
                              logic fl, logic ps, logic [31:0] tg, bit ctg);
        exp_t e;
        e.nm = nm; e.rd = rd; e.crd = crd; e.st = st;
        e.fl = fl; e.ps = ps; e.tg = tg; e.ctg = ctg;
        sb.push_back(e);
    endtask

    // Plain read: set-bits with a zero operand.
    task automatic rd(string nm, logic [11:0] a, logic [31:0] req);
        drv(1'b1, 32'h200, 1'b1, 2'b10, a, 32'h0);
        expect_out(nm, req, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
    endtask

    task automatic wr(string nm, logic [1:0] ty, logic [11:0] a,
                      logic [31:0] wd, logic [31:0] old);
        drv(1'b1, 32'h200, 1'b1, ty, a, wd);
        expect_out(nm, old, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
    endtask

    initial begin
        nxt();
        drv(1'b0, 32'h0, 1'b0, 2'b00, 12'h000, 32'h0);
        expect_out("reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        nxt();
        reset = 1'b1;
        repeat (5) nxt();

        rd("cycle5", 12'hC00, 32'd5);
        rd("mstatus_rst", 12'h300, 32'h1800);
        wr("mtvec_rw", 2'b01, 12'h305, 32'h0000_1003, 32'h0);
        rd("mtvec_rd", 12'h305, 32'h0000_1000);
        rd("cycleh", 12'hC80, 32'h0);
        wr("set_mie", 2'b10, 12'h300, 32'h8, 32'h1800);
        wr("set_meie", 2'b10, 12'h304, 32'h800, 32'h0);
        wr("unk_wr", 2'b01, 12'h7C0, 32'hFFFF, 32'h0);
        rd("unk_rd", 12'h7C0, 32'h0);

        ext_irq = 1'b1;
        drv(1'b1, 32'h40, 1'b1, 2'b01, 12'h341, 32'h1234);
        expect_out("irq_ext", 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b1);
        nxt();
        ext_irq = 1'b0;
        rd("mepc_ext", 12'h341, 32'h40);
        rd("mcause_ext", 12'h342, 32'h8000_000B);
        rd("mstatus_ext", 12'h300, 32'h1880);

        dm_stall = 1'b1;
        drv(1'b1, 32'h44, 1'b1, 2'b00, 12'h302, 32'h0);
        expect_out("mret_held", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        dm_stall = 1'b0;
        expect_out("mret_fire", 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1);
        nxt();
        rd("mstatus_mret", 12'h300, 32'h1888);

        wr("mie_mtie", 2'b01, 12'h304, 32'h80, 32'h800);
        drv(1'b1, 32'h80, 1'b1, 2'b00, 12'h105, 32'h0);
        expect_out("wfi_enter", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        expect_out("wfi_hold", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        timer_irq = 1'b1;
        expect_out("wfi_irq", 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b1);
        nxt();
        rd("mip_timer", 12'h344, 32'h80);
        timer_irq = 1'b0;
        rd("mepc_wfi", 12'h341, 32'h84);
        rd("mcause_tmr", 12'h342, 32'h8000_0007);
        rd("mstatus_wfi", 12'h300, 32'h1880);

        drv(1'b1, 32'h80, 1'b1, 2'b00, 12'h105, 32'h0);
        expect_out("wfi2_enter", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        expect_out("wfi2_hold", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        timer_irq = 1'b1;
        expect_out("wfi2_wake", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        expect_out("wfi2_nop", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        timer_irq = 1'b0;
        rd("mepc_keep", 12'h341, 32'h84);

        instr_retire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr("instret_wr", 2'b01, 12'hC02, 32'h55, i);
        end
        instr_retire = 1'b0;
        rd("instret3", 12'hC02, 32'd3);
        rd("instreth", 12'hC82, 32'h0);

        wr("rc_mie", 2'b11, 12'h304, 32'h80, 32'h80);
        rd("mie_clr", 12'h304, 32'h0);
        wr("rc_zero", 2'b11, 12'h300, 32'h0, 32'h1880);
        rd("mstatus_keep", 12'h300, 32'h1880);

        drv(1'b0, 32'h0, 1'b0, 2'b00, 12'h000, 32'h0);
        nxt();
        nxt();
        chk("drain", "queue", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
